// File: rtl/level_tile_renderer.sv
// level_tile_renderer
//
// Tile-map level renderer for the VGA path. The level is held in a writable
// tile RAM of 3-bit codes, addressed as {row, col}. Each visible pixel is
// mapped to a tile through a horizontal scroll offset, then to a colour
// through a fixed palette. A second read port serves collision queries.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   x, y, active_pixels pixel stream from vga_driver
//   frame_start         one-cycle pulse at start of vertical blank
//   scroll_en/step      advance scroll_pos by scroll_step on frame_start
//   scroll_pos          current scroll offset in pixels
//   wr_en/col/row/tile  tile write port; wr_ready high once the map is cleared
//   q_req/col/row       collision query; q_ack/q_tile two cycles later
//   color_out           registered RGB (R in [23:16]), three cycles after x/y
//   color_valid         active_pixels delayed to match color_out

module level_tile_renderer #(
    parameter int TILE_LOG2 = 4,
    parameter int MAP_COLS  = 64,
    parameter int MAP_ROWS  = 30,
    parameter int STEP_W    = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [9:0]                              x,
    input  logic [9:0]                              y,
    input  logic                                    active_pixels,
    input  logic                                    frame_start,
    input  logic                                    scroll_en,
    input  logic [STEP_W-1:0]                       scroll_step,
    output logic [$clog2(MAP_COLS)+TILE_LOG2-1:0]   scroll_pos,
    input  logic                                    wr_en,
    input  logic [$clog2(MAP_COLS)-1:0]             wr_col,
    input  logic [4:0]                              wr_row,
    input  logic [2:0]                              wr_tile,
    output logic                                    wr_ready,
    input  logic                                    q_req,
    input  logic [$clog2(MAP_COLS)-1:0]             q_col,
    input  logic [4:0]                              q_row,
    output logic                                    q_ack,
    output logic [2:0]                              q_tile,
    output logic [23:0]                             color_out,
    output logic                                    color_valid
);

    localparam int COL_W    = $clog2(MAP_COLS);
    localparam int ROW_W    = 5;
    localparam int ADDR_W   = ROW_W + COL_W;
    localparam int SCROLL_W = COL_W + TILE_LOG2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_COLS * MAP_ROWS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    logic [2:0] tile_mem [0:(1 << ADDR_W) - 1];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [2:0]        mem_wdata;

    // Render pipeline registers
    logic [ADDR_W-1:0] rd_addr_s1;
    logic              in_map_s1;
    logic              active_s1;
    logic [2:0]        rd_tile_s2;
    logic              in_map_s2;
    logic              active_s2;

    // Query pipeline registers
    logic [2:0] q_rd_tile;
    logic       q_req_s1;
    logic       q_in_range_s1;

    // Stage-1 combinational mapping of the pixel into map coordinates
    logic [SCROLL_W-1:0] world_x;
    logic [9:0]          row_full;
    logic [COL_W-1:0]    pix_col;

    function automatic logic [23:0] palette(input logic [2:0] code);
        case (code)
            3'd0:    palette = 24'hC0C0C0;
            3'd1:    palette = 24'h505050;
            3'd2:    palette = 24'hFF4500;
            3'd3:    palette = 24'hFF8C00;
            3'd4:    palette = 24'hFFD700;
            default: palette = 24'h000000;
        endcase
    endfunction

    // Controller: after reset every address is cleared to code 0, one per
    // cycle, before external writes are accepted. wr_ready is registered
    // alongside the state so it rises on the same edge RUN is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state    <= RUN;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= CLEAR;
                    clr_cnt  <= '0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Write-port arbitration: the clear counter owns the RAM during CLEAR,
    // so external writes in that window are simply dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                mem_wdata = 3'd0;
            end else if (wr_en && (int'(wr_row) < MAP_ROWS)) begin
                mem_we    = 1'b1;
                mem_waddr = {wr_row, wr_col};
                mem_wdata = wr_tile;
            end
        end
    end

    // Tile RAM: one write port, two synchronous read ports. Reads scheduled
    // on the same edge as a write return the previous contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            tile_mem[mem_waddr] <= mem_wdata;
        end
        rd_tile_s2 <= tile_mem[rd_addr_s1];
        q_rd_tile  <= tile_mem[{q_row, q_col}];
    end

    // Scroll offset only moves on frame_start so a frame never tears; the
    // sum wraps naturally at the map width in pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_pos <= '0;
        end else if (frame_start && scroll_en) begin
            scroll_pos <= scroll_pos + SCROLL_W'(scroll_step);
        end
    end

    always_comb begin
        world_x  = SCROLL_W'(x) + scroll_pos;
        row_full = y >> TILE_LOG2;
        pix_col  = world_x[SCROLL_W-1:TILE_LOG2];
    end

    // Render pipeline: S1 address, S2 RAM read, S3 palette. Tiles outside
    // the map or read while clearing render as background.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_s1  <= '0;
            in_map_s1   <= 1'b0;
            active_s1   <= 1'b0;
            in_map_s2   <= 1'b0;
            active_s2   <= 1'b0;
            color_out   <= '0;
            color_valid <= 1'b0;
        end else begin
            rd_addr_s1 <= {row_full[ROW_W-1:0], pix_col};
            in_map_s1  <= (int'(row_full) < MAP_ROWS);
            active_s1  <= active_pixels;

            in_map_s2  <= in_map_s1;
            active_s2  <= active_s1;

            color_valid <= active_s2;
            if (!active_s2) begin
                color_out <= '0;
            end else if (!in_map_s2 || (state == CLEAR)) begin
                color_out <= palette(3'd0);
            end else begin
                color_out <= palette(rd_tile_s2);
            end
        end
    end

    // Query pipeline: the RAM is read on the request edge, the result is
    // qualified and registered one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_req_s1      <= 1'b0;
            q_in_range_s1 <= 1'b0;
            q_ack         <= 1'b0;
            q_tile        <= '0;
        end else begin
            q_req_s1      <= q_req;
            q_in_range_s1 <= (int'(q_row) < MAP_ROWS);
            q_ack         <= q_req_s1;
            if (q_req_s1 && q_in_range_s1 && (state == RUN)) begin
                q_tile <= q_rd_tile;
            end else begin
                q_tile <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_level_tile_renderer.sv
// tb_level_tile_renderer
//
// Directed testbench for level_tile_renderer: map clear timing and restart,
// tile writes and rendering, scrolling with wrap, query pipelining and
// same-cycle write/read ordering.

module tb_level_tile_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active_pixels;
    logic        frame_start;
    logic        scroll_en;
    logic [3:0]  scroll_step;
    logic [9:0]  scroll_pos;
    logic        wr_en;
    logic [5:0]  wr_col;
    logic [4:0]  wr_row;
    logic [2:0]  wr_tile;
    logic        wr_ready;
    logic        q_req;
    logic [5:0]  q_col;
    logic [4:0]  q_row;
    logic        q_ack;
    logic [2:0]  q_tile;
    logic [23:0] color_out;
    logic        color_valid;

    int n_checks = 0;
    int n_pass   = 0;
    int model_scroll = 0;

    level_tile_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .x             (x),
        .y             (y),
        .active_pixels (active_pixels),
        .frame_start   (frame_start),
        .scroll_en     (scroll_en),
        .scroll_step   (scroll_step),
        .scroll_pos    (scroll_pos),
        .wr_en         (wr_en),
        .wr_col        (wr_col),
        .wr_row        (wr_row),
        .wr_tile       (wr_tile),
        .wr_ready      (wr_ready),
        .q_req         (q_req),
        .q_col         (q_col),
        .q_row         (q_row),
        .q_ack         (q_ack),
        .q_tile        (q_tile),
        .color_out     (color_out),
        .color_valid   (color_valid)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeTile(input int col, input int row, input int tile);
        wr_en   = 1'b1;
        wr_col  = 6'(col);
        wr_row  = 5'(row);
        wr_tile = 3'(tile);
        tick();
        wr_en = 1'b0;
    endtask

    // Drive one pixel, hold it for the three-cycle latency, then check
    task automatic applyStimulus(input string tag, input int px, input int py,
                                 input logic act, input logic [23:0] exp_color);
        x             = 10'(px);
        y             = 10'(py);
        active_pixels = act;
        tick();
        tick();
        tick();
        checkOutput({tag, "_color"}, 32'(color_out), 32'(exp_color));
        checkOutput({tag, "_valid"}, 32'(color_valid), 32'(act));
        active_pixels = 1'b0;
    endtask

    task automatic framePulse(input logic en, input int step);
        frame_start = 1'b1;
        scroll_en   = en;
        scroll_step = 4'(step);
        tick();
        frame_start = 1'b0;
        scroll_en   = 1'b0;
        if (en) model_scroll = (model_scroll + step) % 1024;
    endtask

    task automatic queryOne(input string tag, input int col, input int row,
                            input int exp_tile);
        q_req = 1'b1;
        q_col = 6'(col);
        q_row = 5'(row);
        tick();
        q_req = 1'b0;
        tick();
        checkOutput({tag, "_ack"}, 32'(q_ack), 32'd1);
        checkOutput({tag, "_tile"}, 32'(q_tile), 32'(exp_tile));
    endtask

    initial begin
        int cnt;
        int early_ready;
        int step;

        rst = 1'b1;
        x = '0; y = '0; active_pixels = 1'b0;
        frame_start = 1'b0; scroll_en = 1'b0; scroll_step = '0;
        wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_tile = '0;
        q_req = 1'b0; q_col = '0; q_row = '0;

        tick();
        tick();
        checkOutput("rst_scroll_pos", 32'(scroll_pos), 32'd0);
        checkOutput("rst_color_out", 32'(color_out), 32'd0);
        checkOutput("rst_color_valid", 32'(color_valid), 32'd0);
        checkOutput("rst_q_ack", 32'(q_ack), 32'd0);
        checkOutput("rst_q_tile", 32'(q_tile), 32'd0);
        checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
        rst = 1'b0;

        // Run into the clear, render during it, then restart the clear
        early_ready = 0;
        for (int i = 0; i < 997; i++) begin
            tick();
            if (wr_ready) early_ready++;
        end
        applyStimulus("clear_pixel", 40, 360, 1'b1, 24'hC0C0C0);
        checkOutput("clear_no_ready", 32'(early_ready), 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        while (!wr_ready && cnt < 3000) begin
            if (cnt == 1000) begin
                wr_en = 1'b1; wr_col = 6'd7; wr_row = 5'd7; wr_tile = 3'd3;
            end
            tick();
            wr_en = 1'b0;
            cnt++;
        end
        checkOutput("clear_len_after_restart", 32'(cnt), 32'd1920);

        queryOne("dropped_write", 7, 7, 0);
        applyStimulus("run_blank", 40, 360, 1'b1, 24'hC0C0C0);

        // Tile write and render at scroll 0
        writeTile(2, 22, 1);
        applyStimulus("stone", 40, 360, 1'b1, 24'h505050);
        applyStimulus("next_col", 48, 360, 1'b1, 24'hC0C0C0);
        applyStimulus("inactive", 40, 360, 1'b0, 24'h000000);

        // Scrolling
        for (int i = 0; i < 4; i++) framePulse(1'b1, 8);
        checkOutput("scroll_32", 32'(scroll_pos), 32'd32);
        applyStimulus("scrolled_stone", 8, 360, 1'b1, 24'h505050);
        framePulse(1'b0, 8);
        framePulse(1'b0, 5);
        checkOutput("scroll_hold", 32'(scroll_pos), 32'd32);
        frame_start = 1'b0; scroll_en = 1'b1; scroll_step = 4'd9;
        tick(); tick();
        scroll_en = 1'b0;
        checkOutput("scroll_no_pulse", 32'(scroll_pos), 32'd32);

        // Walk the scroll to 1016, then wrap with a step of 15
        cnt = 0;
        while (model_scroll != 1016 && cnt < 200) begin
            step = 1016 - model_scroll;
            if (step > 15) step = 15;
            framePulse(1'b1, step);
            cnt++;
        end
        checkOutput("scroll_1016", 32'(scroll_pos), 32'd1016);
        framePulse(1'b1, 15);
        checkOutput("scroll_wrap", 32'(scroll_pos), 32'd7);
        writeTile(0, 22, 2);
        applyStimulus("wrap_col0", 1020, 360, 1'b1, 24'hFF4500);

        // Back-to-back queries
        q_req = 1'b1; q_col = 6'd2; q_row = 5'd22;
        tick();
        q_col = 6'd29 - 6'd27; q_row = 5'd29;
        tick();
        q_req = 1'b0;
        checkOutput("q_b2b_ack0", 32'(q_ack), 32'd1);
        checkOutput("q_b2b_tile0", 32'(q_tile), 32'd1);
        tick();
        checkOutput("q_b2b_ack1", 32'(q_ack), 32'd1);
        checkOutput("q_b2b_tile1", 32'(q_tile), 32'd0);
        tick();
        checkOutput("q_idle_ack", 32'(q_ack), 32'd0);
        queryOne("q_row31", 2, 31, 0);

        // Same-cycle write and query of one address
        wr_en = 1'b1; wr_col = 6'd5; wr_row = 5'd10; wr_tile = 3'd4;
        q_req = 1'b1; q_col = 6'd5; q_row = 5'd10;
        tick();
        wr_en = 1'b0; q_req = 1'b0;
        tick();
        checkOutput("q_collide_ack", 32'(q_ack), 32'd1);
        checkOutput("q_collide_old", 32'(q_tile), 32'd0);
        queryOne("q_after_write", 5, 10, 4);
        applyStimulus("goal", 80, 160, 1'b1, 24'hFFD700);
        applyStimulus("below_map", 80, 496, 1'b1, 24'hC0C0C0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/level_tile_renderer.md
Name: level_tile_renderer

Overview:
- Tile-map level renderer for the Mario-Dash VGA path; replaces hard-coded rectangle comparisons with a writable tile RAM, palette lookup and horizontal scrolling.
- Consumes the vga_driver pixel stream (x, y, active_pixels) and produces a registered 24-bit colour for VGA_R/G/B.
- A second read port lets game logic query tile codes for collision.
- Level geometry is loaded at run time through a write port instead of being fixed in RTL.

Parameters:
- TILE_LOG2, 4, tile edge = 2^TILE_LOG2 pixels (16).
- MAP_COLS, 64, map columns; must be a power of two.
- MAP_ROWS, 30, map rows; 30*16 = 480 lines.
- STEP_W, 4, width of the per-frame scroll step.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  synchronous active-high reset
- x  in  10  pixel column from vga_driver
- y  in  10  pixel row from vga_driver
- active_pixels  in  1  pixel visible
- frame_start  in  1  one-cycle pulse at start of vertical blank
- scroll_en  in  1  advance scroll at next frame_start
- scroll_step  in  STEP_W  pixels to advance per frame
- scroll_pos  out  log2(MAP_COLS)+TILE_LOG2  current scroll offset in pixels
- wr_en  in  1  tile write request
- wr_col  in  log2(MAP_COLS)  write column
- wr_row  in  5  write row
- wr_tile  in  3  tile code
- wr_ready  out  1  writes accepted this cycle
- q_req  in  1  collision query request
- q_col  in  log2(MAP_COLS)  query column
- q_row  in  5  query row
- q_ack  out  1  query result valid pulse
- q_tile  out  3  queried tile code
- color_out  out  24  RGB, R in [23:16]
- color_valid  out  1  active_pixels delayed to match color_out

Behaviour:
- Reset values:
  - scroll_pos = 0, color_out = 0, color_valid = 0.
  - q_ack = 0, q_tile = 0, wr_ready = 0.
  - FSM enters CLEAR.
- FSM CLEAR:
  - Internal counter writes code 0 to every address 0..MAP_COLS*MAP_ROWS-1, one per cycle.
  - wr_ready = 0; external writes are dropped, not queued.
  - Transition to RUN the cycle after the last address is written.
  - Total duration MAP_COLS*MAP_ROWS cycles (1920 with defaults).
- FSM RUN:
  - wr_ready = 1; a write with wr_en=1 lands in one cycle.
  - Writes with wr_row >= MAP_ROWS are ignored.
- rst asserted at any time, including mid-CLEAR: the clear counter restarts at 0.
- Address mapping: address = row*MAP_COLS + col, formed by concatenation {row, col}.
- Render pipeline, fixed latency 3 cycles (inputs at cycle N give color_out/color_valid at N+3):
  - S1: world_x = (x + scroll_pos) mod (MAP_COLS << TILE_LOG2). col = world_x >> TILE_LOG2. row = y >> TILE_LOG2. in_map = (row < MAP_ROWS).
  - S2: synchronous RAM read.
  - S3: palette lookup, registered. Tile code = 0 if !in_map or FSM is in CLEAR.
  - color_out = 0 whenever the delayed active flag is 0.
- Palette:
  - 0 background C0C0C0
  - 1 stone 505050
  - 2 lava FF4500
  - 3 lava glow FF8C00
  - 4 goal gold FFD700
  - 5-7 000000
- Scroll:
  - Updated only on the frame_start cycle: if scroll_en, scroll_pos <= scroll_pos + scroll_step, wrapping modulo MAP_COLS << TILE_LOG2 (1024).
  - scroll_pos is otherwise constant, so no tearing within a frame.
- Query port:
  - q_req at cycle N gives q_ack=1 and q_tile at N+2. Fully pipelined, one request per cycle.
  - q_row >= MAP_ROWS returns 0.
  - During CLEAR, q_tile = 0 but q_ack still pulses.
- Collisions:
  - Write and render/query read of the same address in the same cycle: the read returns the old data.
  - Clear-counter writes take priority over everything.

Test Plan:
- Reset held 1 cycle then released:
  - wr_ready stays 0 for exactly 1920 cycles, then 1.
  - All pixels render C0C0C0.
  - Reasserting rst at cycle 1000 restarts the 1920-cycle count.
- In RUN, write tile 1 at (col 2, row 22), scroll 0; drive x=40, y=360, active=1:
  - color_out = 505050 three cycles later.
  - x=48 gives C0C0C0.
  - active=0 gives 000000 and color_valid=0.
- scroll_en=1, scroll_step=8, four frame_start pulses:
  - scroll_pos = 32.
  - Pixel x=8, y=360 now renders the tile at col 2.
  - Pulses with scroll_en=0 leave scroll_pos unchanged.
- Preload scroll_pos = 1016, step 15, one frame_start:
  - scroll_pos = 7 (wrap).
  - x=1020 maps to world_x 3, col 0.
- q_req on (2,22) and (2,29) back-to-back:
  - q_ack high two consecutive cycles with q_tile = 1 then 0.
  - Query row 31 returns 0.
- Same-cycle write of tile 4 and q_req to (5,10):
  - q_tile = old value 0.
  - Repeat query returns 4; render shows FFD700 there.
